// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the multi-cycle divider: FSM states, ALU function codes
// for the M-extension divide group, and small decode helpers.
package div_sequencer_pkg;

  localparam int DIV_ITERATIONS = 32;

  localparam logic [4:0] ALU_ADD  = 5'h00;
  localparam logic [4:0] ALU_SUB  = 5'h01;
  localparam logic [4:0] ALU_AND  = 5'h02;
  localparam logic [4:0] ALU_OR   = 5'h03;
  localparam logic [4:0] ALU_XOR  = 5'h04;
  localparam logic [4:0] ALU_DIV  = 5'h10;
  localparam logic [4:0] ALU_DIVU = 5'h11;
  localparam logic [4:0] ALU_REM  = 5'h12;
  localparam logic [4:0] ALU_REMU = 5'h13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic is_div_op(input logic [4:0] f);
    return (f == ALU_DIV) || (f == ALU_DIVU) || (f == ALU_REM) || (f == ALU_REMU);
  endfunction

  function automatic logic is_rem_op(input logic [4:0] f);
    return (f == ALU_REM) || (f == ALU_REMU);
  endfunction

  function automatic logic is_signed_op(input logic [4:0] f);
    return (f == ALU_DIV) || (f == ALU_REM);
  endfunction

endpackage

// File: rtl/div_sequencer_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the divisor,
// keep the difference and set the quotient LSB when it does not go negative.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;
  logic             keep;

  // One spare bit above the remainder register catches the borrow of the trial subtract.
  assign shifted  = {rem, quo[WIDTH-1]};
  assign diff     = shifted - {2'b00, divisor};
  assign keep     = ~diff[WIDTH+1];
  assign rem_next = keep ? diff[WIDTH:0] : shifted[WIDTH:0];
  assign quo_next = {quo[WIDTH-2:0], keep};

endmodule

// File: rtl/div_sequencer.sv
// Radix-2 restoring divide/remainder sequencer (DIV, DIVU, REM, REMU) beside the ALU.
// One quotient bit per cycle; special cases can short-circuit straight to DONE.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             request_valid,
  output logic             request_ready,
  input  logic [4:0]       alu_function,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV_ITERATIONS - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [CW-1:0]    counter;
  logic [4:0]       func;
  logic [WIDTH-1:0] raw_a;
  logic             sign_b;
  logic             b_zero;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] div_q;

  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] quo_next;

  logic             in_signed;
  logic             in_neg_a;
  logic             in_neg_b;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic             in_overflow;
  logic             accept;

  logic             sign_a;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] result_fix;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (div_q),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  assign accept      = request_valid && request_ready;
  assign in_signed   = is_signed_op(alu_function);
  assign in_neg_a    = in_signed && operand_a[WIDTH-1];
  assign in_neg_b    = in_signed && operand_b[WIDTH-1];
  assign abs_a       = in_neg_a ? -operand_a : operand_a;
  assign abs_b       = in_neg_b ? -operand_b : operand_b;
  assign in_overflow = in_signed && (operand_a == MOST_NEG) && (operand_b == '1);

  // A zero divisor leaves the quotient all-ones regardless of the dividend sign.
  assign sign_a     = is_signed_op(func) && raw_a[WIDTH-1];
  assign quo_fix    = ((sign_a ^ sign_b) && !b_zero) ? -quo_q : quo_q;
  assign rem_fix    = sign_a ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
  assign result_fix = is_rem_op(func) ? rem_fix : quo_fix;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      counter       <= '0;
      func          <= ALU_ADD;
      raw_a         <= '0;
      sign_b        <= 1'b0;
      b_zero        <= 1'b0;
      rem_q         <= '0;
      quo_q         <= '0;
      div_q         <= '0;
      result        <= '0;
      result_valid  <= 1'b0;
      busy          <= 1'b0;
      request_ready <= 1'b1;
    end else if (flush) begin
      state         <= IDLE;
      counter       <= '0;
      result_valid  <= 1'b0;
      busy          <= 1'b0;
      request_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            func          <= alu_function;
            raw_a         <= operand_a;
            sign_b        <= in_neg_b;
            b_zero        <= (operand_b == '0);
            busy          <= 1'b1;
            request_ready <= 1'b0;
            if (!is_div_op(alu_function)) begin
              result       <= '0;
              result_valid <= 1'b1;
              state        <= DONE;
            end else if (FAST_SPECIAL && (operand_b == '0)) begin
              result       <= is_rem_op(alu_function) ? operand_a : '1;
              result_valid <= 1'b1;
              state        <= DONE;
            end else if (FAST_SPECIAL && in_overflow) begin
              result       <= is_rem_op(alu_function) ? '0 : MOST_NEG;
              result_valid <= 1'b1;
              state        <= DONE;
            end else begin
              counter <= '0;
              rem_q   <= '0;
              quo_q   <= abs_a;
              div_q   <= abs_b;
              state   <= ITER;
            end
          end
        end
        ITER: begin
          rem_q   <= rem_next;
          quo_q   <= quo_next;
          counter <= counter + 1'b1;
          if (counter == CNT_LAST) begin
            state <= FIX;
          end
        end
        FIX: begin
          result       <= result_fix;
          result_valid <= 1'b1;
          state        <= DONE;
        end
        DONE: begin
          if (result_ready) begin
            result_valid  <= 1'b0;
            busy          <= 1'b0;
            request_ready <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Randomized and directed bench for div_sequencer: one fast-special instance and one
// fully iterative instance, compared against arithmetic reference results and latencies.
module tb_div_sequencer;
  import div_sequencer_pkg::*;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [1:0]  req;
  logic [1:0]  rq;
  logic [1:0]  rv;
  logic [1:0]  bz;
  logic [4:0]  func;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        result_ready;
  logic [31:0] res [2];

  int nvec;
  int nerr;

  div_sequencer #(.WIDTH(32), .FAST_SPECIAL(1'b1)) dut_fast (
    .clock         (clk),
    .reset         (reset),
    .flush         (flush),
    .request_valid (req[0]),
    .request_ready (rq[0]),
    .alu_function  (func),
    .operand_a     (op_a),
    .operand_b     (op_b),
    .result_valid  (rv[0]),
    .result_ready  (result_ready),
    .result        (res[0]),
    .busy          (bz[0])
  );

  div_sequencer #(.WIDTH(32), .FAST_SPECIAL(1'b0)) dut_slow (
    .clock         (clk),
    .reset         (reset),
    .flush         (flush),
    .request_valid (req[1]),
    .request_ready (rq[1]),
    .alu_function  (func),
    .operand_a     (op_a),
    .operand_b     (op_b),
    .result_valid  (rv[1]),
    .result_ready  (result_ready),
    .result        (res[1]),
    .busy          (bz[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [4:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (f == ALU_DIV) begin
      if (b == 0) return 32'hFFFF_FFFF;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
      return sa / sb;
    end
    if (f == ALU_REM) begin
      if (b == 0) return a;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
      return sa % sb;
    end
    if (f == ALU_DIVU) return (b == 0) ? 32'hFFFF_FFFF : a / b;
    if (f == ALU_REMU) return (b == 0) ? a : a % b;
    return 32'h0;
  endfunction

  function automatic int ref_latency(input int sel, input logic [4:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
    logic ovf;
    ovf = (f == ALU_DIV || f == ALU_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    if (!(f == ALU_DIV || f == ALU_DIVU || f == ALU_REM || f == ALU_REMU)) return 1;
    if (sel == 0 && (b == 0 || ovf)) return 1;
    return 34;
  endfunction

  task automatic run_op(input int sel, input logic [4:0] f, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    logic [31:0] exp;
    int          exp_lat;
    int          cyc;
    exp     = ref_result(f, a, b);
    exp_lat = ref_latency(sel, f, a, b);
    @(negedge clk);
    check("req_ready_idle", 32'(rq[sel]), 32'd1);
    func = f; op_a = a; op_b = b; req[sel] = 1'b1;
    @(posedge clk);
    #1 req[sel] = 1'b0;
    cyc = 1;
    @(negedge clk);
    while (!rv[sel] && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("latency", 32'(cyc), 32'(exp_lat));
    check("result", res[sel], exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(rv[sel]), 32'd1);
      check("hold_busy", 32'(bz[sel]), 32'd1);
      check("hold_req_ready", 32'(rq[sel]), 32'd0);
      check("hold_result", res[sel], exp);
    end
    result_ready = 1'b1;
    @(posedge clk);
    #1 result_ready = 1'b0;
    @(negedge clk);
    check("post_valid", 32'(rv[sel]), 32'd0);
    check("post_busy", 32'(bz[sel]), 32'd0);
  endtask

  task automatic check_reset_outputs(input int sel);
    check("rst_result", res[sel], 32'h0);
    check("rst_valid", 32'(rv[sel]), 32'd0);
    check("rst_busy", 32'(bz[sel]), 32'd0);
    check("rst_req_ready", 32'(rq[sel]), 32'd1);
  endtask

  logic [4:0] funcs [5];

  initial begin
    nvec = 0;
    nerr = 0;
    funcs[0] = ALU_ADD; funcs[1] = ALU_DIV; funcs[2] = ALU_DIVU;
    funcs[3] = ALU_REM; funcs[4] = ALU_REMU;
    reset = 1'b1; flush = 1'b0; req = 2'b00; func = ALU_ADD;
    op_a = '0; op_b = '0; result_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_outputs(0);
    check_reset_outputs(1);

    run_op(0, ALU_DIV,  32'hFFFF_FFEC, 32'd3, 0);
    run_op(0, ALU_REM,  32'hFFFF_FFEC, 32'd3, 0);
    run_op(0, ALU_DIVU, 32'hFFFF_FFFF, 32'd2, 5);
    run_op(0, ALU_REMU, 32'hFFFF_FFFF, 32'd2, 5);
    for (int s = 0; s < 2; s++) begin
      run_op(s, ALU_DIV,  32'd7, 32'd0, 1);
      run_op(s, ALU_REM,  32'd7, 32'd0, 1);
      run_op(s, ALU_DIV,  32'hFFFF_FFF9, 32'd0, 0);
      run_op(s, ALU_DIVU, 32'd7, 32'd0, 0);
      run_op(s, ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op(s, ALU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 0);
    end

    // Flush in cycle 10 of a DIV, with a request presented alongside that must be dropped.
    @(negedge clk);
    func = ALU_DIV; op_a = 32'd1000; op_b = 32'd3; req[0] = 1'b1;
    @(posedge clk);
    #1 req[0] = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1; req[0] = 1'b1; func = ALU_DIVU; op_a = 32'd5; op_b = 32'd1;
    @(posedge clk);
    #1 flush = 1'b0; req[0] = 1'b0;
    @(negedge clk);
    check("flush_req_ready", 32'(rq[0]), 32'd1);
    check("flush_valid", 32'(rv[0]), 32'd0);
    check("flush_busy", 32'(bz[0]), 32'd0);
    run_op(0, ALU_DIVU, 32'd100, 32'd7, 0);

    // Reset mid-ITER with an ADD request held on the inputs.
    @(negedge clk);
    func = ALU_DIV; op_a = 32'h1234_5678; op_b = 32'd9; req[0] = 1'b1;
    @(posedge clk);
    #1 req[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1; req[0] = 1'b1; func = ALU_ADD;
    @(posedge clk);
    #1 reset = 1'b0; req[0] = 1'b0;
    @(negedge clk);
    check_reset_outputs(0);
    run_op(0, ALU_ADD, 32'd3, 32'd4, 0);

    for (int n = 0; n < 40; n++) begin
      int          sel;
      logic [4:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      int          kind;
      sel  = int'($urandom_range(1, 0));
      f    = funcs[$urandom_range(4, 0)];
      a    = $urandom;
      b    = $urandom;
      kind = int'($urandom_range(7, 0));
      if (kind == 0) b = 32'h0;
      else if (kind == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (kind == 2) b = $urandom_range(15, 1);
      else if (kind == 3) b = -$urandom_range(15, 1);
      else if (kind == 4) a = $urandom_range(200, 0);
      run_op(sel, f, a, b, int'($urandom_range(2, 0)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
